// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit that owns the HI/LO registers.
// A launched mult/div latches its full result at the launch edge and then
// holds Busy for a fixed latency before committing to HI/LO. Divide by zero
// runs the full latency but leaves HI/LO untouched.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic [2:0]  MDControl,
    input  logic        Start,
    input  logic        IntReq,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_MULTU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_MTHI  = 3'b101;
    localparam logic [2:0] MD_MTLO  = 3'b110;

    // Signed 32x32 -> 64 product.
    function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = 64'($signed(a)) * 64'($signed(b));
        return p;
    endfunction

    // Signed division on magnitudes: quotient truncates toward zero, remainder
    // takes the dividend's sign. The most-negative / -1 case falls out as
    // quotient 0x80000000, remainder 0 without special handling.
    function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ua, ub, uq, ur, q, r;
        ua = a[31] ? (32'd0 - a) : a;
        ub = b[31] ? (32'd0 - b) : b;
        if (ub == 32'd0) begin
            uq = 32'd0;
            ur = 32'd0;
        end else begin
            uq = ua / ub;
            ur = ua % ub;
        end
        q = (a[31] ^ b[31]) ? (32'd0 - uq) : uq;
        r = a[31] ? (32'd0 - ur) : ur;
        return {r, q};
    endfunction

    // Unsigned division returning {remainder, quotient}.
    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) begin
            return 64'd0;
        end else begin
            return {a % b, a / b};
        end
    endfunction

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        tmp_hi_q, tmp_hi_d;
    logic [31:0]        tmp_lo_q, tmp_lo_d;
    logic               skip_q, skip_d;
    logic               launch_s;
    logic [63:0]        res_s;

    assign launch_s = Start && !IntReq && (MDControl >= MD_MULT) && (MDControl <= MD_DIVU);

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

    // State and datapath registers; reset aborts any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
            skip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            skip_q   <= skip_d;
        end
    end

    // Next-state: launch from IDLE, return when the countdown reaches its last cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (launch_s) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operation result selected by the launching control code.
    always_comb begin
        res_s = 64'd0;
        case (MDControl)
            MD_MULT:  res_s = mul_signed(D1, D2);
            MD_MULTU: res_s = {32'd0, D1} * {32'd0, D2};
            MD_DIV:   res_s = div_signed(D1, D2);
            MD_DIVU:  res_s = div_unsigned(D1, D2);
            default:  res_s = 64'd0;
        endcase
    end

    // Outputs and datapath: latch result at launch, count down, commit on exit.
    always_comb begin
        busy_d   = (state_d == ST_BUSY);
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        skip_d   = skip_q;
        case (state_q)
            ST_IDLE: begin
                if (launch_s) begin
                    tmp_hi_d = res_s[63:32];
                    tmp_lo_d = res_s[31:0];
                    if ((MDControl == MD_DIV) || (MDControl == MD_DIVU)) begin
                        cnt_d  = CNT_W'(DIV_CYCLES);
                        skip_d = (D2 == 32'd0);
                    end else begin
                        cnt_d  = CNT_W'(MULT_CYCLES);
                        skip_d = 1'b0;
                    end
                end else if (!IntReq && (MDControl == MD_MTHI)) begin
                    hi_d = D1;
                end else if (!IntReq && (MDControl == MD_MTLO)) begin
                    lo_d = D1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if ((cnt_q == CNT_W'(1)) && !skip_q) begin
                    hi_d = tmp_hi_q;
                    lo_d = tmp_lo_q;
                end else begin
                    hi_d = hi_q;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

endmodule
